router_port_rx: RTL and testbench

// - Parametrised input-port receiver for the router's serial packet protocol (din/frame_n/valid_n).
// - Deserialises address, pad and payload bits into address-tagged bytes.
// - Buffers bytes in a FIFO and presents them on a valid/ready stream to the switch core.
// - Drives busy_n back to the source.
// - Protocol errors are detected and flagged; the offending frame is discarded.
// - One instance per input port; NUM_PORTS instances are generated by the router top.

---
 rtl/router_pkg.sv | 17 +
 rtl/router_sync_fifo.sv | 47 ++++
 rtl/router_port_rx.sv | 158 +++++++++++++++
 tb/tb_router_port_rx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and default sizing for the router's serial input ports.
package router_pkg;

    localparam int ROUTER_NUM_PORTS = 16;
    localparam int ROUTER_ADDR_W    = 4;
    localparam int ROUTER_DATA_W    = 8;
    localparam int ROUTER_PAD_CYC   = 5;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_ADDR,
        RX_PAD,
        RX_DATA,
        RX_DISCARD
    } rx_state_e;

endpackage

// File: rtl/router_sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit so full and empty
// are distinguishable without a separate counter.
module router_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign pop_en  = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign push_en = push && (!full || pop_en);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/router_port_rx.sv
// Serial packet receiver for one router input port: deserialises address and payload,
// queues address-tagged words and flags protocol, partial-word and overflow errors.
module router_port_rx
    import router_pkg::*;
#(
    parameter int ADDR_W     = ROUTER_ADDR_W,
    parameter int DATA_W     = ROUTER_DATA_W,
    parameter int PAD_CYC    = ROUTER_PAD_CYC,
    parameter bit STRICT_PAD = 1'b1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              din,
    input  logic              frame_n,
    input  logic              valid_n,
    output logic              busy_n,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_sop,
    output logic              m_eop,
    output logic              err_proto,
    output logic              err_part,
    output logic              err_ovf
);
    localparam int CNT_W   = $clog2((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1;
    localparam int PAD_W   = $clog2(PAD_CYC + 1);
    localparam int ENTRY_W = DATA_W + ADDR_W + 2;
    localparam int FCNT_W  = $clog2(FIFO_DEPTH) + 1;

    rx_state_e         state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [PAD_W-1:0]  pad_cnt;
    logic [ADDR_W-1:0] addr_sr;
    logic [DATA_W-2:0] data_sr;
    logic              first_word;

    logic               push;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FCNT_W-1:0]  fifo_count;
    logic [FCNT_W-1:0]  count_next;
    logic               pop;

    // The final payload bit goes straight into the FIFO on the edge that samples it.
    assign push       = (state == RX_DATA) && !valid_n && (bit_cnt == CNT_W'(DATA_W - 1));
    assign push_entry = {first_word, frame_n, addr_sr, din, data_sr};
    assign m_valid    = !fifo_empty;
    assign pop        = m_valid && m_ready;
    assign count_next = fifo_count + FCNT_W'(push && (!fifo_full || pop)) - FCNT_W'(pop);
    assign {m_sop, m_eop, m_addr, m_data} = m_valid ? rd_entry : '0;

    router_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .wr_data (push_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            pad_cnt    <= '0;
            addr_sr    <= '0;
            data_sr    <= '0;
            first_word <= 1'b0;
            busy_n     <= 1'b1;
            err_proto  <= 1'b0;
            err_part   <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            err_proto <= 1'b0;
            err_part  <= 1'b0;
            err_ovf   <= push && fifo_full && !pop;
            busy_n    <= (count_next < FCNT_W'(FIFO_DEPTH - 2));
            case (state)
                RX_IDLE: begin
                    if (!frame_n) begin
                        addr_sr    <= (addr_sr >> 1) | (ADDR_W'(din) << (ADDR_W - 1));
                        bit_cnt    <= CNT_W'(1);
                        pad_cnt    <= '0;
                        first_word <= 1'b1;
                        state      <= (ADDR_W > 1) ? RX_ADDR : RX_PAD;
                    end
                end
                RX_ADDR: begin
                    if (frame_n) begin
                        err_proto <= 1'b1;
                        state     <= RX_IDLE;
                    end else begin
                        addr_sr <= (addr_sr >> 1) | (ADDR_W'(din) << (ADDR_W - 1));
                        if (bit_cnt == CNT_W'(ADDR_W - 1)) state <= RX_PAD;
                        else bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_PAD: begin
                    if (frame_n) begin
                        err_proto <= 1'b1;
                        state     <= RX_IDLE;
                    end else if (STRICT_PAD) begin
                        if (!valid_n) begin
                            err_proto <= 1'b1;
                            state     <= RX_DISCARD;
                        end else if (pad_cnt == PAD_W'(PAD_CYC - 1)) begin
                            bit_cnt <= '0;
                            state   <= RX_DATA;
                        end else begin
                            pad_cnt <= pad_cnt + 1'b1;
                        end
                    end else if (!valid_n) begin
                        // Relaxed padding: this cycle already carries payload bit 0.
                        data_sr <= (data_sr >> 1) | ((DATA_W - 1)'(din) << (DATA_W - 2));
                        bit_cnt <= CNT_W'(1);
                        state   <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (!valid_n) begin
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            first_word <= 1'b0;
                            bit_cnt    <= '0;
                            if (frame_n) state <= RX_IDLE;
                        end else begin
                            data_sr <= (data_sr >> 1) | ((DATA_W - 1)'(din) << (DATA_W - 2));
                            if (frame_n) begin
                                err_part <= 1'b1;
                                state    <= RX_IDLE;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else if (frame_n) begin
                        err_part <= 1'b1;
                        state    <= RX_IDLE;
                    end
                end
                RX_DISCARD: begin
                    if (frame_n) state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_port_rx.sv
// Directed bench for router_port_rx: serial frames in, stream words and error pulses checked
// against hand-computed {sop, eop, addr, data} entries.
module tb_router_port_rx;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       din;
    logic       frame_n;
    logic       valid_n;
    logic       m_ready;
    logic       busy_n;
    logic       m_valid;
    logic [7:0] m_data;
    logic [3:0] m_addr;
    logic       m_sop;
    logic       m_eop;
    logic       err_proto;
    logic       err_part;
    logic       err_ovf;

    int total_checks  = 0;
    int passed_checks = 0;
    int n_proto = 0;
    int n_part  = 0;
    int n_ovf   = 0;
    logic [13:0] rx_q [$];

    router_port_rx #(
        .ADDR_W     (4),
        .DATA_W     (8),
        .PAD_CYC    (5),
        .STRICT_PAD (1'b1),
        .FIFO_DEPTH (16)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .din       (din),
        .frame_n   (frame_n),
        .valid_n   (valid_n),
        .busy_n    (busy_n),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_addr    (m_addr),
        .m_sop     (m_sop),
        .m_eop     (m_eop),
        .err_proto (err_proto),
        .err_part  (err_part),
        .err_ovf   (err_ovf)
    );

    always #5 clock = ~clock;

    // Inputs change 2 time units after each rising edge, so the falling edge sees a stable handshake.
    always @(negedge clock) begin
        if (reset_n) begin
            if (m_valid && m_ready) rx_q.push_back({m_sop, m_eop, m_addr, m_data});
            if (err_proto) n_proto++;
            if (err_part)  n_part++;
            if (err_ovf)   n_ovf++;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) passed_checks++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            frame_n = 1'b1;
            valid_n = 1'b1;
            din     = 1'b1;
            tick();
        end
    endtask

    task automatic send_header(input logic [3:0] addr, input int bad_pad);
        for (int i = 0; i < 4; i++) begin
            frame_n = 1'b0;
            valid_n = 1'b1;
            din     = addr[i];
            tick();
        end
        for (int p = 0; p < 5; p++) begin
            frame_n = 1'b0;
            valid_n = (p == bad_pad) ? 1'b0 : 1'b1;
            din     = 1'b1;
            tick();
        end
    endtask

    task automatic send_byte(input logic [7:0] data, input bit last, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            frame_n = (last && (b == nbits - 1)) ? 1'b1 : 1'b0;
            valid_n = 1'b0;
            din     = data[b];
            tick();
        end
    endtask

    initial begin
        int base;
        int p0;
        int q0;
        int o0;
        int eops;

        reset_n = 1'b0;
        frame_n = 1'b1;
        valid_n = 1'b1;
        din     = 1'b1;
        m_ready = 1'b0;
        tick();
        tick();
        check_output("rst_busy_n",  busy_n,    1);
        check_output("rst_m_valid", m_valid,   0);
        check_output("rst_m_sop",   m_sop,     0);
        check_output("rst_m_eop",   m_eop,     0);
        check_output("rst_m_data",  m_data,    0);
        check_output("rst_m_addr",  m_addr,    0);
        check_output("rst_errs",    {err_proto, err_part, err_ovf}, 0);
        reset_n = 1'b1;
        idle(2);

        $display("[TB] basic frame addr A, bytes 5C 31");
        m_ready = 1'b1;
        base = rx_q.size(); p0 = n_proto; q0 = n_part; o0 = n_ovf;
        send_header(4'hA, -1);
        send_byte(8'h5C, 1'b0, 8);
        check_output("lat_m_valid", m_valid, 1);
        check_output("lat_m_data",  m_data,  8'h5C);
        check_output("lat_m_addr",  m_addr,  4'hA);
        check_output("lat_m_sop",   m_sop,   1);
        send_byte(8'h31, 1'b1, 8);
        idle(4);
        check_output("basic_count", rx_q.size() - base, 2);
        check_output("basic_w0",    rx_q[base],     {1'b1, 1'b0, 4'hA, 8'h5C});
        check_output("basic_w1",    rx_q[base + 1], {1'b0, 1'b1, 4'hA, 8'h31});
        check_output("basic_errs",  (n_proto - p0) + (n_part - q0) + (n_ovf - o0), 0);

        $display("[TB] three back-to-back frames");
        base = rx_q.size(); p0 = n_proto; q0 = n_part; o0 = n_ovf;
        send_header(4'h3, -1);
        send_byte(8'h11, 1'b1, 8);
        send_header(4'hC, -1);
        send_byte(8'h22, 1'b0, 8);
        send_byte(8'h33, 1'b1, 8);
        send_header(4'h7, -1);
        send_byte(8'h44, 1'b1, 8);
        idle(4);
        check_output("b2b_count", rx_q.size() - base, 4);
        check_output("b2b_w0",    rx_q[base],     {1'b1, 1'b1, 4'h3, 8'h11});
        check_output("b2b_w1",    rx_q[base + 1], {1'b1, 1'b0, 4'hC, 8'h22});
        check_output("b2b_w2",    rx_q[base + 2], {1'b0, 1'b1, 4'hC, 8'h33});
        check_output("b2b_w3",    rx_q[base + 3], {1'b1, 1'b1, 4'h7, 8'h44});
        check_output("b2b_errs",  (n_proto - p0) + (n_part - q0) + (n_ovf - o0), 0);

        $display("[TB] valid_n low in pad cycle 3");
        base = rx_q.size(); p0 = n_proto; q0 = n_part;
        send_header(4'h2, 2);
        send_byte(8'h77, 1'b1, 8);
        send_header(4'h5, -1);
        send_byte(8'hA7, 1'b1, 8);
        idle(4);
        check_output("pad_err_proto", n_proto - p0, 1);
        check_output("pad_err_part",  n_part - q0, 0);
        check_output("pad_count",     rx_q.size() - base, 1);
        check_output("pad_next_w0",   rx_q[base], {1'b1, 1'b1, 4'h5, 8'hA7});

        $display("[TB] frame ends after 5 bits of the second word");
        base = rx_q.size(); p0 = n_proto; q0 = n_part;
        send_header(4'h6, -1);
        send_byte(8'h96, 1'b0, 8);
        send_byte(8'h0B, 1'b1, 5);
        idle(4);
        check_output("part_err_part",  n_part - q0, 1);
        check_output("part_err_proto", n_proto - p0, 0);
        check_output("part_count",     rx_q.size() - base, 1);
        check_output("part_w0",        rx_q[base], {1'b1, 1'b0, 4'h6, 8'h96});

        $display("[TB] 20-byte frame into a stalled 16-entry FIFO");
        m_ready = 1'b0;
        base = rx_q.size(); o0 = n_ovf;
        send_header(4'hE, -1);
        for (int i = 0; i < 20; i++) begin
            send_byte(8'h10 + 8'(i), (i == 19), 8);
            if (i == 12) check_output("ovf_busy_at13", busy_n, 1);
            if (i == 13) check_output("ovf_busy_at14", busy_n, 0);
        end
        idle(2);
        check_output("ovf_err_count", n_ovf - o0, 4);
        check_output("ovf_head_data", m_data, 8'h10);
        check_output("ovf_head_sop",  m_sop, 1);
        check_output("ovf_head_addr", m_addr, 4'hE);
        m_ready = 1'b1;
        idle(20);
        check_output("ovf_drain_count", rx_q.size() - base, 16);
        eops = 0;
        for (int i = base; i < rx_q.size(); i++) eops += int'(rx_q[i][12]);
        check_output("ovf_drain_eops", eops, 0);
        check_output("ovf_drain_last", rx_q[base + 15], {1'b0, 1'b0, 4'hE, 8'h1F});
        check_output("ovf_busy_after", busy_n, 1);

        $display("[TB] reset mid-payload");
        m_ready = 1'b0;
        base = rx_q.size(); p0 = n_proto; q0 = n_part; o0 = n_ovf;
        send_header(4'h2, -1);
        send_byte(8'h44, 1'b1, 8);
        check_output("rst_pre_m_valid", m_valid, 1);
        send_header(4'h9, -1);
        send_byte(8'h0F, 1'b0, 4);
        reset_n = 1'b0;
        #1;
        check_output("rst_mid_m_valid", m_valid, 0);
        check_output("rst_mid_m_data",  m_data, 0);
        check_output("rst_mid_m_addr",  m_addr, 0);
        check_output("rst_mid_sop_eop", {m_sop, m_eop}, 0);
        check_output("rst_mid_busy_n",  busy_n, 1);
        frame_n = 1'b1;
        valid_n = 1'b1;
        tick();
        reset_n = 1'b1;
        m_ready = 1'b1;
        idle(2);
        send_header(4'h9, -1);
        send_byte(8'h3E, 1'b1, 8);
        idle(4);
        check_output("rst_next_count", rx_q.size() - base, 1);
        check_output("rst_next_w0",    rx_q[base], {1'b1, 1'b1, 4'h9, 8'h3E});
        check_output("rst_next_errs",  (n_proto - p0) + (n_part - q0) + (n_ovf - o0), 0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
